// File: rtl/rs_csee_sched.sv
// ---------------------------------------------------------------------------
// rs_csee_sched
//   Job scheduler between the RS(255) key-equation stage (KES) and the
//   Chien-search / Forney stage (CSEE). Coefficient sets from KES are queued
//   in a small FIFO. One CSEE run is launched per codeword, and the FIFO head
//   is held on rs_lambda*/rs_omega* for the whole search. The error-data
//   window is marked with win_first/win_last/win_tag. The fail verdict is
//   returned as a tagged status through a valid/ready handshake.
//
// Optional feature (macro RS_CSEE_SCHED_STATS_EN):
//   When defined, this adds the saturating counters stat_words and stat_fails.
//   stat_words counts every status handshake. stat_fails counts the
//   handshakes that carry st_fail=1.
//
// Ports:
//   clk, rstn            clock; synchronous active-low reset
//   sched_ena            launch enable, forwarded as rs_ena
//   kes_valid/kes_ready  coefficient-set handshake into the FIFO
//   kes_lambda0..2       error-locator coefficients
//   kes_omega0..1        evaluator coefficients
//   kes_tag              codeword tag
//   rs_ena               CSEE global enable
//   csee_ena             one-cycle CSEE start
//   csee_ongo            CSEE busy
//   rs_lambda*/rs_omega* coefficients to CSEE (0 when no search is running)
//   rsdec_fail           CSEE fail verdict
//   win_valid/first/last error-data window markers
//   win_tag              tag of the current window (0 outside the window)
//   st_valid/st_ready    status handshake
//   st_fail, st_tag      codeword status
//   proto_err            sticky flag: csee_ongo was low inside a window
// ---------------------------------------------------------------------------
module rs_csee_sched #(
  parameter int DEPTH       = 2,
  parameter int TAG_W       = 4,
  parameter int CSEE_CYCLES = 24,
  parameter int FAIL_LAT    = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sched_ena,
  input  logic             kes_valid,
  output logic             kes_ready,
  input  logic [7:0]       kes_lambda0,
  input  logic [7:0]       kes_lambda1,
  input  logic [7:0]       kes_lambda2,
  input  logic [7:0]       kes_omega0,
  input  logic [7:0]       kes_omega1,
  input  logic [TAG_W-1:0] kes_tag,
  output logic             rs_ena,
  output logic             csee_ena,
  input  logic             csee_ongo,
  output logic [7:0]       rs_lambda0,
  output logic [7:0]       rs_lambda1,
  output logic [7:0]       rs_lambda2,
  output logic [7:0]       rs_omega0,
  output logic [7:0]       rs_omega1,
  input  logic             rsdec_fail,
  output logic             win_valid,
  output logic             win_first,
  output logic             win_last,
  output logic [TAG_W-1:0] win_tag,
  output logic             st_valid,
  input  logic             st_ready,
  output logic             st_fail,
  output logic [TAG_W-1:0] st_tag,
  output logic             proto_err
`ifdef RS_CSEE_SCHED_STATS_EN
  ,
  output logic [15:0]      stat_words,
  output logic [15:0]      stat_fails
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = 40 + TAG_W;
  localparam int CNT_W = $clog2(CSEE_CYCLES);
  localparam int WC_W  = (FAIL_LAT > 1) ? $clog2(FAIL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CSEE_CYCLES - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(FAIL_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SEARCH,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t state, state_n;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic [ENT_W-1:0] head;
  logic [TAG_W-1:0] head_tag;
  logic [CNT_W-1:0] cnt;
  logic [WC_W-1:0]  wcnt;
  logic [TAG_W-1:0] job_tag;
  logic             launch_ok, coef_on, handshake;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign kes_ready = !full;
  assign push      = kes_valid & kes_ready;
  assign head      = mem[rd_ptr];
  assign head_tag  = head[ENT_W-1:40];
  assign rs_ena    = sched_ena;
  assign handshake = st_valid & st_ready;

  // The head is retired on the last search cycle. The next job therefore
  // becomes the head while the current job is still in WAIT/REPORT.
  assign pop = (state == S_SEARCH) && (cnt == CNT_LAST);

  // st_valid is deliberately left out of this term. REPORT folds the clearing
  // of st_valid and the next launch into one cycle, so that the launch-to-launch
  // spacing is CSEE_CYCLES+FAIL_LAT+1.
  assign launch_ok = !empty & sched_ena & !csee_ongo;

  // Coefficient storage. The entries need no reset because count gates their use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {kes_tag, kes_omega1, kes_omega0,
                      kes_lambda2, kes_lambda1, kes_lambda0};
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Next-state and window outputs.
  always_comb begin
    state_n   = state;
    csee_ena  = 1'b0;
    win_valid = 1'b0;
    win_first = 1'b0;
    win_last  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (launch_ok && !st_valid) state_n = S_LAUNCH;
      end
      S_LAUNCH: begin
        csee_ena  = 1'b1;
        win_valid = 1'b1;
        win_first = 1'b1;
        state_n   = S_SEARCH;
      end
      S_SEARCH: begin
        win_valid = 1'b1;
        if (cnt == CNT_LAST) begin
          win_last = 1'b1;
          state_n  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt == WC_LAST) state_n = S_REPORT;
      end
      S_REPORT: begin
        if (handshake) state_n = launch_ok ? S_LAUNCH : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, search/wait counters and status capture.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wcnt      <= '0;
      job_tag   <= '0;
      st_valid  <= 1'b0;
      st_fail   <= 1'b0;
      st_tag    <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_LAUNCH: begin
          cnt     <= CNT_W'(1);
          job_tag <= head_tag;
        end
        S_SEARCH: begin
          cnt  <= cnt + CNT_W'(1);
          wcnt <= '0;
        end
        S_WAIT: begin
          wcnt <= wcnt + WC_W'(1);
          if (wcnt == WC_LAST) begin
            st_valid <= 1'b1;
            st_fail  <= rsdec_fail;
            st_tag   <= job_tag;
          end
        end
        S_REPORT: begin
          if (handshake) st_valid <= 1'b0;
        end
        default: ;
      endcase
      if (win_valid && !csee_ongo) proto_err <= 1'b1;
    end
  end

  assign coef_on    = (state == S_LAUNCH) || (state == S_SEARCH);
  assign rs_lambda0 = coef_on ? head[7:0]   : 8'd0;
  assign rs_lambda1 = coef_on ? head[15:8]  : 8'd0;
  assign rs_lambda2 = coef_on ? head[23:16] : 8'd0;
  assign rs_omega0  = coef_on ? head[31:24] : 8'd0;
  assign rs_omega1  = coef_on ? head[39:32] : 8'd0;
  assign win_tag    = win_valid ? head_tag : '0;

`ifdef RS_CSEE_SCHED_STATS_EN
  // Saturating job and failure counters. They advance only on status handshakes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_words <= 16'd0;
      stat_fails <= 16'd0;
    end else if (handshake) begin
      if (stat_words != 16'hFFFF) stat_words <= stat_words + 16'd1;
      if (st_fail && stat_fails != 16'hFFFF) stat_fails <= stat_fails + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_csee_sched.sv
// Testbench for rs_csee_sched (default build, statistics counters absent).
module tb_rs_csee_sched;

  logic       clk, rstn, sched_ena, kes_valid, kes_ready;
  logic [7:0] kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1;
  logic [3:0] kes_tag;
  logic       rs_ena, csee_ena, csee_ongo;
  logic [7:0] rs_lambda0, rs_lambda1, rs_lambda2, rs_omega0, rs_omega1;
  logic       rsdec_fail, win_valid, win_first, win_last;
  logic [3:0] win_tag;
  logic       st_valid, st_ready, st_fail;
  logic [3:0] st_tag;
  logic       proto_err;
  logic       ongo_drop;

  int         cyc;
  int         n_cmp;
  int         n_bad;
  int         launch_q[$];
  logic [3:0] tag_q[$];

  typedef struct {
    int         off;
    logic       csee;
    logic       wv;
    logic       wf;
    logic       wl;
    logic [3:0] wt;
    logic [7:0] l0;
    logic       sv;
    logic [3:0] stag;
    logic       sf;
  } row_t;
  row_t tbl [9];

  rs_csee_sched dut (
    .clk(clk), .rstn(rstn), .sched_ena(sched_ena),
    .kes_valid(kes_valid), .kes_ready(kes_ready),
    .kes_lambda0(kes_lambda0), .kes_lambda1(kes_lambda1), .kes_lambda2(kes_lambda2),
    .kes_omega0(kes_omega0), .kes_omega1(kes_omega1), .kes_tag(kes_tag),
    .rs_ena(rs_ena), .csee_ena(csee_ena), .csee_ongo(csee_ongo),
    .rs_lambda0(rs_lambda0), .rs_lambda1(rs_lambda1), .rs_lambda2(rs_lambda2),
    .rs_omega0(rs_omega0), .rs_omega1(rs_omega1),
    .rsdec_fail(rsdec_fail),
    .win_valid(win_valid), .win_first(win_first), .win_last(win_last), .win_tag(win_tag),
    .st_valid(st_valid), .st_ready(st_ready), .st_fail(st_fail), .st_tag(st_tag),
    .proto_err(proto_err)
  );

  // The CSEE model is busy exactly while the window is open, unless the bench drops it.
  assign csee_ongo = win_valid & ~ongo_drop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record launch cycles and completed status handshakes.
  always @(negedge clk) begin
    if (csee_ena) launch_q.push_back(cyc);
    if (st_valid && st_ready) tag_q.push_back(st_tag);
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] tag, input logic [7:0] l0,
                               input logic [7:0] l1, input logic [7:0] l2,
                               input logic [7:0] o0, input logic [7:0] o1);
    kes_valid   = v;
    kes_tag     = tag;
    kes_lambda0 = l0;
    kes_lambda1 = l1;
    kes_lambda2 = l2;
    kes_omega0  = o0;
    kes_omega1  = o1;
  endtask

  // Returns at the negedge of the launch cycle. On timeout, the cycle index is returned as -1.
  task automatic waitLaunch(input int bound, output int lc);
    bit found = 0;
    lc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (csee_ena) begin
        found = 1;
        lc = cyc;
        break;
      end
      tick();
    end
    if (!found) checkOutput("launch_timeout", 32'(found), 32'(1));
  endtask

  task automatic waitStatus(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (tag_q.size() >= n) break;
      tick();
    end
    checkOutput("status_count", 32'(tag_q.size()), 32'(n));
  endtask

  initial begin
    int p, lc, l1, ready_cyc, unstable, hcyc, extra;
    cyc = 0; n_cmp = 0; n_bad = 0;
    rstn = 1'b0; sched_ena = 1'b0; st_ready = 1'b0; rsdec_fail = 1'b0; ongo_drop = 1'b0;
    applyStimulus(0, 4'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

    // Expected timeline of a single job relative to its launch cycle L.
    tbl[0] = '{0,  1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 8'd1, 1'b0, 4'd0, 1'b0};
    tbl[1] = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 8'd1, 1'b0, 4'd0, 1'b0};
    tbl[2] = '{12, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 8'd1, 1'b0, 4'd0, 1'b0};
    tbl[3] = '{22, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 8'd1, 1'b0, 4'd0, 1'b0};
    tbl[4] = '{23, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 8'd1, 1'b0, 4'd0, 1'b0};
    tbl[5] = '{24, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0};
    tbl[6] = '{25, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0};
    tbl[7] = '{26, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 1'b1};
    tbl[8] = '{27, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0};

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_kes_ready", 32'(kes_ready), 32'(1));
    checkOutput("rst_csee_ena",  32'(csee_ena),  32'(0));
    checkOutput("rst_win_valid", 32'(win_valid), 32'(0));
    checkOutput("rst_st_valid",  32'(st_valid),  32'(0));
    checkOutput("rst_st_tag",    32'(st_tag),    32'(0));
    checkOutput("rst_proto_err", 32'(proto_err), 32'(0));
    checkOutput("rst_lambda0",   32'(rs_lambda0), 32'(0));
    checkOutput("rst_rs_ena",    32'(rs_ena),    32'(0));
    tick();
    rstn = 1'b1;

    // Test 1: single job, table-driven timeline
    $display("[TB] single job timeline");
    st_ready = 1'b1; sched_ena = 1'b1;
    applyStimulus(1, 4'd3, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    p = cyc;
    @(negedge clk);
    checkOutput("t1_rs_ena", 32'(rs_ena), 32'(1));
    tick();
    applyStimulus(0, 4'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    waitLaunch(10, lc);
    checkOutput("t1_launch_cycle", 32'(lc), 32'(p + 2));
    for (int off = 0; off <= 27; off++) begin
      if (off > 0) begin
        tick();
        rsdec_fail = (off == 25);
        @(negedge clk);
      end
      for (int r = 0; r < 9; r++) begin
        if (tbl[r].off == off) begin
          checkOutput($sformatf("t1_csee_ena@%0d", off),  32'(csee_ena),  32'(tbl[r].csee));
          checkOutput($sformatf("t1_win_valid@%0d", off), 32'(win_valid), 32'(tbl[r].wv));
          checkOutput($sformatf("t1_win_first@%0d", off), 32'(win_first), 32'(tbl[r].wf));
          checkOutput($sformatf("t1_win_last@%0d", off),  32'(win_last),  32'(tbl[r].wl));
          checkOutput($sformatf("t1_win_tag@%0d", off),   32'(win_tag),   32'(tbl[r].wt));
          checkOutput($sformatf("t1_lambda0@%0d", off),   32'(rs_lambda0), 32'(tbl[r].l0));
          checkOutput($sformatf("t1_st_valid@%0d", off),  32'(st_valid),  32'(tbl[r].sv));
          if (tbl[r].sv) begin
            checkOutput($sformatf("t1_st_tag@%0d", off),  32'(st_tag),  32'(tbl[r].stag));
            checkOutput($sformatf("t1_st_fail@%0d", off), 32'(st_fail), 32'(tbl[r].sf));
          end
        end
      end
    end
    tick();
    rsdec_fail = 1'b0;

    // Test 2: three back-to-back pushes into a two-entry FIFO
    $display("[TB] back-to-back pushes");
    launch_q.delete(); tag_q.delete();
    applyStimulus(1, 4'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0);
    p = cyc;
    tick();
    applyStimulus(1, 4'd6, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    applyStimulus(1, 4'd7, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    checkOutput("t2_ready_full", 32'(kes_ready), 32'(0));
    ready_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      @(negedge clk);
      if (kes_ready) begin
        ready_cyc = cyc;
        break;
      end
    end
    l1 = (launch_q.size() > 0) ? launch_q[0] : -1;
    checkOutput("t2_first_launch", 32'(l1), 32'(p + 2));
    checkOutput("t2_ready_after_pop", 32'(ready_cyc), 32'(l1 + 24));
    tick();
    applyStimulus(0, 4'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    waitStatus(3, 150);
    if (launch_q.size() == 3) begin
      checkOutput("t2_spacing_1", 32'(launch_q[1] - launch_q[0]), 32'(27));
      checkOutput("t2_spacing_2", 32'(launch_q[2] - launch_q[1]), 32'(27));
    end else begin
      checkOutput("t2_launch_count", 32'(launch_q.size()), 32'(3));
    end
    if (tag_q.size() == 3) begin
      checkOutput("t2_tag0", 32'(tag_q[0]), 32'(5));
      checkOutput("t2_tag1", 32'(tag_q[1]), 32'(6));
      checkOutput("t2_tag2", 32'(tag_q[2]), 32'(7));
    end

    // Test 3: status back-pressure holds st_* and blocks the next launch
    $display("[TB] status back-pressure");
    tick();
    launch_q.delete(); tag_q.delete();
    st_ready = 1'b0;
    applyStimulus(1, 4'd9, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    applyStimulus(1, 4'd10, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    applyStimulus(0, 4'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (st_valid) break;
      tick();
    end
    checkOutput("t3_st_valid", 32'(st_valid), 32'(1));
    unstable = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      rsdec_fail = ~rsdec_fail;
      @(negedge clk);
      if (!st_valid || st_tag != 4'd9 || st_fail != 1'b0) unstable++;
    end
    checkOutput("t3_unstable_cycles", 32'(unstable), 32'(0));
    checkOutput("t3_launches_in_hold", 32'(launch_q.size()), 32'(1));
    tick();
    st_ready = 1'b1; rsdec_fail = 1'b0;
    hcyc = cyc;
    waitStatus(2, 60);
    l1 = (launch_q.size() > 1) ? launch_q[1] : -1;
    checkOutput("t3_relaunch_cycle", 32'(l1), 32'(hcyc + 1));
    if (tag_q.size() == 2) begin
      checkOutput("t3_tag0", 32'(tag_q[0]), 32'(9));
      checkOutput("t3_tag1", 32'(tag_q[1]), 32'(10));
    end

    // Test 4: csee_ongo dropped mid-window
    $display("[TB] protocol error");
    tick();
    launch_q.delete(); tag_q.delete();
    @(negedge clk);
    checkOutput("t4_proto_before", 32'(proto_err), 32'(0));
    tick();
    applyStimulus(1, 4'd11, 8'd11, 8'd27, 8'd43, 8'd59, 8'd75);
    tick();
    applyStimulus(0, 4'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    waitLaunch(10, lc);
    checkOutput("t4_lambda0", 32'(rs_lambda0), 32'(11));
    checkOutput("t4_lambda1", 32'(rs_lambda1), 32'(27));
    checkOutput("t4_lambda2", 32'(rs_lambda2), 32'(43));
    checkOutput("t4_omega0",  32'(rs_omega0),  32'(59));
    checkOutput("t4_omega1",  32'(rs_omega1),  32'(75));
    repeat (10) tick();
    ongo_drop = 1'b1;
    @(negedge clk);
    checkOutput("t4_proto_same_cycle", 32'(proto_err), 32'(0));
    tick();
    ongo_drop = 1'b0;
    @(negedge clk);
    checkOutput("t4_proto_set", 32'(proto_err), 32'(1));
    tick();
    waitStatus(1, 40);
    if (tag_q.size() == 1) checkOutput("t4_tag", 32'(tag_q[0]), 32'(11));
    checkOutput("t4_proto_sticky", 32'(proto_err), 32'(1));

    // Test 5: reset in the middle of a search, then sched_ena gating
    $display("[TB] reset mid-run");
    launch_q.delete(); tag_q.delete();
    applyStimulus(1, 4'd12, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    applyStimulus(1, 4'd13, 8'd13, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    applyStimulus(0, 4'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    waitLaunch(10, lc);
    repeat (10) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("t5_csee_ena",  32'(csee_ena),  32'(0));
    checkOutput("t5_win_valid", 32'(win_valid), 32'(0));
    checkOutput("t5_win_first", 32'(win_first), 32'(0));
    checkOutput("t5_win_last",  32'(win_last),  32'(0));
    checkOutput("t5_win_tag",   32'(win_tag),   32'(0));
    checkOutput("t5_lambda0",   32'(rs_lambda0), 32'(0));
    checkOutput("t5_st_valid",  32'(st_valid),  32'(0));
    checkOutput("t5_st_fail",   32'(st_fail),   32'(0));
    checkOutput("t5_st_tag",    32'(st_tag),    32'(0));
    checkOutput("t5_proto_err", 32'(proto_err), 32'(0));
    checkOutput("t5_kes_ready", 32'(kes_ready), 32'(1));
    launch_q.delete(); tag_q.delete();
    repeat (40) tick();
    checkOutput("t5_no_launch_after_rst", 32'(launch_q.size()), 32'(0));
    checkOutput("t5_no_status_after_rst", 32'(tag_q.size()), 32'(0));

    sched_ena = 1'b0;
    applyStimulus(1, 4'd14, 8'd14, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    applyStimulus(0, 4'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (15) tick();
    checkOutput("t5_gated_launch", 32'(launch_q.size()), 32'(0));
    sched_ena = 1'b1;
    waitStatus(1, 60);
    if (tag_q.size() == 1) checkOutput("t5_tag", 32'(tag_q[0]), 32'(14));
    extra = launch_q.size();
    checkOutput("t5_launch_count", 32'(extra), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
